// File: rtl/ring_freq_counter.sv
// Ring-oscillator frequency counter. It synchronises ring_in, counts its rising
// edges over a window of GATE_CYCLES clk cycles, and latches the count for readout.
module ring_freq_counter #(
    parameter int GATE_CYCLES = 1024,
    parameter int COUNT_W     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ring_in,
    input  logic               enable,
    input  logic               start,
    input  logic               continuous,
    output logic [COUNT_W-1:0] count_out,
    output logic               overflow,
    output logic               valid,
    output logic               busy
);

    localparam int WIN_W = $clog2(GATE_CYCLES);
    localparam logic [WIN_W-1:0]   WIN_LAST = WIN_W'(GATE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX  = {COUNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise_s;
    state_e                 state_q, state_d;
    logic [WIN_W-1:0]       win_q, win_d;
    logic [COUNT_W-1:0]     edge_q, edge_d;
    logic                   ovf_q, ovf_d;
    logic [COUNT_W-1:0]     count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;

    // Synchroniser chain plus the previous-sample flop used for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{1'b0}};
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ring_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Rings faster than clk/2 alias here; nothing detects that.
    assign rise_s = sync_q[SYNC_STAGES-1] & ~prev_q;

    // Next-state, window/edge counting and result latching.
    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        edge_d     = edge_q;
        ovf_d      = ovf_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        case (state_q)
            IDLE: begin
                if (enable && (start || continuous)) begin
                    state_d = GATE;
                    win_d   = {WIN_W{1'b0}};
                    edge_d  = {COUNT_W{1'b0}};
                    ovf_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            GATE: begin
                if (!enable) begin
                    state_d = IDLE;
                end else begin
                    if (rise_s) begin
                        if (edge_q == CNT_MAX) begin
                            ovf_d = 1'b1;
                        end else begin
                            edge_d = edge_q + COUNT_W'(1);
                        end
                    end else begin
                        edge_d = edge_q;
                    end
                    // The rise seen in the final window cycle is part of the result.
                    if (win_q == WIN_LAST) begin
                        count_d    = edge_d;
                        overflow_d = ovf_d;
                        state_d    = DONE;
                    end else begin
                        win_d = win_q + WIN_W'(1);
                    end
                end
            end
            DONE: begin
                if (enable && continuous) begin
                    state_d = GATE;
                    win_d   = {WIN_W{1'b0}};
                    edge_d  = {COUNT_W{1'b0}};
                    ovf_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        valid_d = (state_d == DONE);
        busy_d  = (state_d != IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            win_q      <= {WIN_W{1'b0}};
            edge_q     <= {COUNT_W{1'b0}};
            ovf_q      <= 1'b0;
            count_q    <= {COUNT_W{1'b0}};
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            edge_q     <= edge_d;
            ovf_q      <= ovf_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
        end
    end

    assign count_out = count_q;
    assign overflow  = overflow_q;
    assign valid     = valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ring_freq_counter.sv
// Self-checking bench for ring_freq_counter: a 16-bit and a saturating 8-bit instance
// share all inputs and are checked against a sample-stream edge-count model.
module tb_ring_freq_counter;

    localparam int G      = 1024;
    localparam int S      = 2;
    localparam int HIST_N = 32768;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ring_in = 1'b0;
    logic        enable = 1'b1;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic [15:0] count16;
    logic        ovf16, valid16, busy16;
    logic [7:0]  count8;
    logic        ovf8, valid8, busy8;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic hist [HIST_N];
    int   ring_mode = 0;
    int   ring_half = 4;
    int   ph = 0;
    logic ring_level = 1'b0;

    ring_freq_counter #(.GATE_CYCLES(G), .COUNT_W(16), .SYNC_STAGES(S)) u_dut (
        .clk(clk), .rst(rst), .ring_in(ring_in), .enable(enable), .start(start),
        .continuous(continuous), .count_out(count16), .overflow(ovf16),
        .valid(valid16), .busy(busy16)
    );

    ring_freq_counter #(.GATE_CYCLES(G), .COUNT_W(8), .SYNC_STAGES(S)) u_sat (
        .clk(clk), .rst(rst), .ring_in(ring_in), .enable(enable), .start(start),
        .continuous(continuous), .count_out(count8), .overflow(ovf8),
        .valid(valid8), .busy(busy8)
    );

    always #5 clk = ~clk;

    // Record the ring value seen at every rising clk edge.
    always @(posedge clk) begin
        if (cyc < HIST_N) hist[cyc] <= ring_in;
        cyc <= cyc + 1;
    end

    // Ring stimulus: 0 constant, 1 square wave of period 2*ring_half, 2 random.
    always @(negedge clk) begin
        case (ring_mode)
            0: ring_in <= ring_level;
            1: begin
                if (ph >= ring_half - 1) begin
                    ph <= 0;
                    ring_in <= ~ring_in;
                end else begin
                    ph <= ph + 1;
                end
            end
            default: ring_in <= 1'($urandom_range(0, 1));
        endcase
    end

    // Rises on the sampled stream, delayed by the synchroniser depth, over the
    // G-cycle window starting at edge e; saturating at 2^w-1.
    function automatic void model(input int e, input int w, output int cnt, output bit ovf);
        int mx;
        mx  = (1 << w) - 1;
        cnt = 0;
        ovf = 1'b0;
        for (int m = e - S + 1; m <= e + G - S; m++) begin
            if (hist[m] === 1'b1 && hist[m-1] === 1'b0) begin
                if (cnt == mx) ovf = 1'b1;
                else cnt++;
            end
        end
    endfunction

    task automatic measure(output int e, output int lat, output bit busy_ok, output bit after_ok);
        int n;
        busy_ok = 1'b1;
        @(negedge clk);
        start = 1'b1;
        e = cyc;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (valid16 !== 1'b1 && n < G + 20) begin
            if (busy16 !== 1'b1 || busy8 !== 1'b1 || valid8 !== 1'b0) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        lat = (valid16 === 1'b1) ? n : -1;
        if (busy16 !== 1'b1 || valid8 !== 1'b1) busy_ok = 1'b0;
        @(negedge clk);
        after_ok = (valid16 === 1'b0 && busy16 === 1'b0 && valid8 === 1'b0);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (count16 !== 16'd0 || ovf16 !== 1'b0) begin n_fail++; $display("FAIL reset_result: got %0d/%0b expected 0/0", count16, ovf16); end
        n_checks++; if (valid16 !== 1'b0 || busy16 !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got valid=%0b busy=%0b expected 0/0", valid16, busy16); end
        rst = 1'b0;
        repeat (12) @(negedge clk);
        n_checks++; if (busy16 !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got busy=%0b expected 0", busy16); end
    endtask

    task automatic test_single();
        int e, lat;
        bit bok, aok;
        ring_mode = 1; ring_half = 4;
        repeat (12) @(negedge clk);
        measure(e, lat, bok, aok);
        n_checks++; if (lat !== G + 1) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d", lat, G + 1); end
        n_checks++; if (count16 !== 16'd128 || ovf16 !== 1'b0) begin n_fail++; $display("FAIL single_count: got %0d/%0b expected 128/0", count16, ovf16); end
        n_checks++; if (count8 !== 8'd128 || ovf8 !== 1'b0) begin n_fail++; $display("FAIL single_count8: got %0d/%0b expected 128/0", count8, ovf8); end
        n_checks++; if (!bok) begin n_fail++; $display("FAIL single_busy: got busy gap expected busy high throughout"); end
        n_checks++; if (!aok) begin n_fail++; $display("FAIL single_after: got valid=%0b busy=%0b expected 0/0", valid16, busy16); end
    endtask

    task automatic test_max_and_constant();
        int e, lat;
        bit bok, aok;
        ring_mode = 1; ring_half = 1;
        repeat (12) @(negedge clk);
        measure(e, lat, bok, aok);
        n_checks++; if (count16 !== 16'd512 || ovf16 !== 1'b0) begin n_fail++; $display("FAIL max_rate: got %0d/%0b expected 512/0", count16, ovf16); end
        n_checks++; if (count8 !== 8'd255 || ovf8 !== 1'b1) begin n_fail++; $display("FAIL saturate: got %0d/%0b expected 255/1", count8, ovf8); end
        ring_mode = 1; ring_half = 8;
        repeat (12) @(negedge clk);
        measure(e, lat, bok, aok);
        n_checks++; if (count8 !== 8'd64 || ovf8 !== 1'b0) begin n_fail++; $display("FAIL sat_recover: got %0d/%0b expected 64/0", count8, ovf8); end
        n_checks++; if (count16 !== 16'd64) begin n_fail++; $display("FAIL period16: got %0d expected 64", count16); end
        for (int lv = 0; lv < 2; lv++) begin
            ring_mode = 0; ring_level = 1'(lv);
            repeat (12) @(negedge clk);
            measure(e, lat, bok, aok);
            n_checks++; if (count16 !== 16'd0 || lat !== G + 1) begin n_fail++; $display("FAIL constant_%0d: got %0d lat %0d expected 0 lat %0d", lv, count16, lat, G + 1); end
        end
    endtask

    task automatic test_random();
        int e, lat, m16, m8;
        bit bok, aok, o16, o8;
        for (int it = 0; it < 6; it++) begin
            ring_mode = (it % 2 == 0) ? 2 : 1;
            ring_half = $urandom_range(1, 20);
            repeat ($urandom_range(5, 30)) @(negedge clk);
            measure(e, lat, bok, aok);
            model(e, 16, m16, o16);
            model(e, 8, m8, o8);
            n_checks++; if (count16 !== 16'(m16) || ovf16 !== o16 || lat !== G + 1) begin n_fail++; $display("FAIL random16_%0d: got %0d/%0b lat %0d expected %0d/%0b lat %0d", it, count16, ovf16, lat, m16, o16, G + 1); end
            n_checks++; if (count8 !== 8'(m8) || ovf8 !== o8) begin n_fail++; $display("FAIL random8_%0d: got %0d/%0b expected %0d/%0b", it, count8, ovf8, m8, o8); end
        end
    endtask

    task automatic test_continuous();
        int last, pulses;
        bit seen;
        ring_mode = 1; ring_half = 4;
        repeat (12) @(negedge clk);
        continuous = 1'b1;
        last = -1; pulses = 0;
        for (int i = 0; i < 3 * (G + 1) + 60 && pulses < 3; i++) begin
            @(negedge clk);
            if (valid16 === 1'b1) begin
                pulses++;
                n_checks++; if (count16 !== 16'd128) begin n_fail++; $display("FAIL cont_count: got %0d expected 128", count16); end
                if (last >= 0) begin
                    n_checks++; if (cyc - last !== G + 1) begin n_fail++; $display("FAIL cont_spacing: got %0d expected %0d", cyc - last, G + 1); end
                end
                last = cyc;
            end
        end
        n_checks++; if (pulses !== 3) begin n_fail++; $display("FAIL cont_pulses: got %0d expected 3", pulses); end
        repeat (100) @(negedge clk);
        continuous = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < G + 10 && !seen; i++) begin
            @(negedge clk);
            if (valid16 === 1'b1) seen = 1'b1;
        end
        n_checks++; if (!seen || cyc - last !== G + 1) begin n_fail++; $display("FAIL cont_drain: got seen=%0b spacing %0d expected 1 and %0d", seen, cyc - last, G + 1); end
        repeat (3) @(negedge clk);
        n_checks++; if (busy16 !== 1'b0) begin n_fail++; $display("FAIL cont_idle: got busy=%0b expected 0", busy16); end
        continuous = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < G + 20 && !seen; i++) begin
            @(negedge clk);
            if (valid16 === 1'b1) seen = 1'b1;
        end
        enable = 1'b0;
        @(negedge clk);
        n_checks++; if (!seen || busy16 !== 1'b0 || valid16 !== 1'b0) begin n_fail++; $display("FAIL done_disable: got seen=%0b busy=%0b valid=%0b expected 1/0/0", seen, busy16, valid16); end
        continuous = 1'b0;
        @(negedge clk);
        enable = 1'b1;
    endtask

    task automatic test_abort();
        int nv;
        ring_mode = 1; ring_half = 8;
        repeat (12) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (499) @(negedge clk);
        enable = 1'b0;
        nv = 0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (valid16 === 1'b1) nv++;
        end
        n_checks++; if (nv !== 0) begin n_fail++; $display("FAIL abort_valid: got %0d pulses expected 0", nv); end
        n_checks++; if (count16 !== 16'd128 || count8 !== 8'd128) begin n_fail++; $display("FAIL abort_keep: got %0d/%0d expected 128/128", count16, count8); end
        n_checks++; if (busy16 !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got busy=%0b expected 0", busy16); end
        enable = 1'b1;
    endtask

    task automatic test_back_to_back();
        int nv;
        ring_mode = 1; ring_half = 4;
        repeat (12) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nv = 0;
        for (int i = 0; i < 2 * G + 20; i++) begin
            @(negedge clk);
            start = (i == 100 || i == 400 || i == 900) ? 1'b1 : 1'b0;
            if (valid16 === 1'b1) nv++;
        end
        start = 1'b0;
        n_checks++; if (nv !== 1) begin n_fail++; $display("FAIL start_ignored: got %0d pulses expected 1", nv); end
        n_checks++; if (count16 !== 16'd128) begin n_fail++; $display("FAIL start_ignored_count: got %0d expected 128", count16); end
    endtask

    task automatic test_reset_mid();
        int e, lat;
        bit bok, aok;
        ring_mode = 1; ring_half = 1;
        repeat (12) @(negedge clk);
        measure(e, lat, bok, aok);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (300) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (count16 !== 16'd0 || count8 !== 8'd0 || ovf8 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_result: got %0d/%0d/%0b expected 0/0/0", count16, count8, ovf8); end
        n_checks++; if (busy16 !== 1'b0 || valid16 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_flags: got busy=%0b valid=%0b expected 0/0", busy16, valid16); end
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++; if (busy16 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_idle: got busy=%0b expected 0", busy16); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_max_and_constant();
        test_random();
        test_continuous();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
